fc_dma_responder: RTL and testbench

- Services the fully-connected controller's DMA read requests: latches a start address and word count, fetches that many consecutive words from the synchronous weight/bias memory, and streams them to the bus one per cycle.
- Signals completion with a one-cycle `DMA_ready` pulse.
- Sits between the FC controller, the weight memory and the `BUS_DATASRC_DMA` input of the bus mux.
- Absorbs sink backpressure through a one-entry skid buffer.

---
 rtl/fc_dma_responder.sv | 194 +++++++++++++++++++
 tb/tb_fc_dma_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_dma_responder.sv
`default_nettype none
// ============================================================================
// Module  : fc_dma_responder
// Purpose : Serves DMA read requests from the fully-connected controller.
//           Latches a start address and word count, reads that many
//           consecutive words from the synchronous weight/bias memory and
//           streams them out one per cycle. A one-entry skid buffer absorbs
//           sink backpressure. Completion is a one-cycle DMA_ready pulse.
// Ports   : clk, rst (sync, active-low)
//           DMA_read/DMA_address/DMA_count  - request from controller
//           DMA_ready, busy                 - status back to controller
//           mem_rd_en/mem_addr/mem_rdata    - synchronous memory port
//           data_out/data_valid/data_index  - word stream to bus mux
//           out_stall                       - sink backpressure
//           DMA_error                       - only with DMA_ADDR_CHECK_EN
// Options : define DMA_ADDR_CHECK_EN to reject requests running past
//           MEM_DEPTH (ends immediately with DMA_error set).
// Revision: 1.0 - initial release
// ============================================================================
module fc_dma_responder #(
  parameter int MEM_ADDRESS_WIDTH   = 16,
  parameter int LAYER_ADDRESS_WIDTH = 7,
  parameter int DATA_WIDTH          = 16,
  parameter int MEM_DEPTH           = 11014
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           DMA_read,
  input  logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address,
  input  logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count,
  output logic                           DMA_ready,
  output logic                           busy,
  output logic                           mem_rd_en,
  output logic [MEM_ADDRESS_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_valid,
  output logic [LAYER_ADDRESS_WIDTH-1:0] data_index,
  input  logic                           out_stall
`ifdef DMA_ADDR_CHECK_EN
  ,
  output logic                           DMA_error
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [MEM_ADDRESS_WIDTH-1:0]   C_ONE_ADDR = 1;
  localparam logic [LAYER_ADDRESS_WIDTH-1:0] C_ONE_CNT  = 1;

  state_t                           state_q;
  logic [MEM_ADDRESS_WIDTH-1:0]     addr_q;
  logic [LAYER_ADDRESS_WIDTH-1:0]   iss_left_q;   // reads still to issue
  logic [LAYER_ADDRESS_WIDTH-1:0]   cons_left_q;  // words still to deliver
  logic                             inflight_q;   // read issued last cycle
  logic [DATA_WIDTH-1:0]            skid_q;
  logic                             skid_valid_q;
  logic [DATA_WIDTH-1:0]            data_out_q;
  logic                             data_valid_q;
  logic [LAYER_ADDRESS_WIDTH-1:0]   data_index_q;
  logic                             ready_q;
  logic                             busy_q;

  logic issue_d;
  logic consume_d;

  // Reads are suppressed in any stalled cycle, so at most one word can be
  // in flight when a stall starts; that word lands in the skid buffer.
  assign issue_d   = (state_q == S_FETCH) && !out_stall;
  assign consume_d = data_valid_q && !out_stall;

`ifdef DMA_ADDR_CHECK_EN
  logic                         error_q;
  logic [MEM_ADDRESS_WIDTH:0]   end_addr_d;
  logic                         range_err_d;
  localparam logic [MEM_ADDRESS_WIDTH:0] C_DEPTH = MEM_DEPTH[MEM_ADDRESS_WIDTH:0];

  // One extra bit so A+N cannot wrap before the comparison.
  assign end_addr_d  = {1'b0, DMA_address}
                     + {{(MEM_ADDRESS_WIDTH + 1 - LAYER_ADDRESS_WIDTH){1'b0}}, DMA_count};
  assign range_err_d = (DMA_count != '0) && (end_addr_d > C_DEPTH);
  assign DMA_error   = error_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      iss_left_q   <= '0;
      cons_left_q  <= '0;
      inflight_q   <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_index_q <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DMA_ADDR_CHECK_EN
      error_q      <= 1'b0;
`endif
    end else begin
      inflight_q <= issue_d;

      // Output stage: advances only when the sink is not stalling. The
      // skid entry is always older than any in-flight read, so it goes first.
      if (!out_stall) begin
        if (skid_valid_q) begin
          data_out_q   <= skid_q;
          data_valid_q <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (inflight_q) begin
          data_out_q   <= mem_rdata;
          data_valid_q <= 1'b1;
        end else begin
          data_valid_q <= 1'b0;
        end
        if (data_valid_q) begin
          data_index_q <= data_index_q + C_ONE_CNT;
          cons_left_q  <= cons_left_q - C_ONE_CNT;
        end
      end else if (inflight_q) begin
        skid_q       <= mem_rdata;
        skid_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (DMA_read) begin
            addr_q       <= DMA_address;
            iss_left_q   <= DMA_count;
            cons_left_q  <= DMA_count;
            data_index_q <= '0;
            busy_q       <= 1'b1;
`ifdef DMA_ADDR_CHECK_EN
            if (range_err_d) begin
              state_q <= S_DONE;
              ready_q <= 1'b1;
              error_q <= 1'b1;
            end else
`endif
            if (DMA_count == '0) begin
              state_q <= S_DONE;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (issue_d) begin
            addr_q     <= addr_q + C_ONE_ADDR;
            iss_left_q <= iss_left_q - C_ONE_CNT;
            if (iss_left_q == C_ONE_CNT) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The final delivery always happens at least two cycles after
          // the final read, so completion is only detected here.
          if (consume_d && (cons_left_q == C_ONE_CNT)) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
`ifdef DMA_ADDR_CHECK_EN
          error_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DMA_ready  = ready_q;
  assign busy       = busy_q;
  assign mem_rd_en  = issue_d;
  assign mem_addr   = addr_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_index = data_index_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_dma_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fc_dma_responder
// Purpose : Directed self-checking bench for fc_dma_responder. A behavioural
//           synchronous memory returns memval(addr); expected values come
//           from closed-form cycle timing relative to the accept cycle T.
//           Inputs change 1 time unit after the rising edge, outputs are
//           sampled on the falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fc_dma_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        DMA_read;
  logic [15:0] DMA_address;
  logic [6:0]  DMA_count;
  logic        DMA_ready;
  logic        busy;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [6:0]  data_index;
  logic        out_stall;
`ifdef DMA_ADDR_CHECK_EN
  logic        DMA_error;
`endif

  int passed = 0;
  int total  = 0;
  int cnt, rdy_cnt, rdy_cyc;
  logic [15:0] tmp_a;

  fc_dma_responder #(
    .MEM_ADDRESS_WIDTH  (16),
    .LAYER_ADDRESS_WIDTH(7),
    .DATA_WIDTH         (16),
    .MEM_DEPTH          (11014)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DMA_read   (DMA_read),
    .DMA_address(DMA_address),
    .DMA_count  (DMA_count),
    .DMA_ready  (DMA_ready),
    .busy       (busy),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_index (data_index),
    .out_stall  (out_stall)
`ifdef DMA_ADDR_CHECK_EN
    ,
    .DMA_error  (DMA_error)
`endif
  );

  always #5 clk = ~clk;

  // Odd multiplier makes the pattern a bijection: every address differs.
  function automatic logic [15:0] memval(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= memval(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " ready"}, {31'd0, DMA_ready}, 0);
    chk({name, " busy"}, {31'd0, busy}, 0);
    chk({name, " rd_en"}, {31'd0, mem_rd_en}, 0);
    chk({name, " addr"}, {16'd0, mem_addr}, 0);
    chk({name, " data"}, {16'd0, data_out}, 0);
    chk({name, " valid"}, {31'd0, data_valid}, 0);
    chk({name, " index"}, {25'd0, data_index}, 0);
  endtask

  // Unstalled transfer of n words from a. If ign > 0, a different request
  // is pulsed in cycle T+ign and must be ignored.
  task automatic run_clean(input string name, input logic [15:0] a, input logic [6:0] n,
                           input int ign);
    int ni;
    logic [15:0] ea;
    logic exp_rd, exp_v, exp_rdy, exp_busy;
    ni = int'(n);
    @(posedge clk); #1;
    DMA_read = 1'b1; DMA_address = a; DMA_count = n; out_stall = 1'b0;
    @(negedge clk);
    chk($sformatf("%s T busy", name), {31'd0, busy}, 0);
    for (int c = 1; c <= ni + 4; c++) begin
      @(posedge clk); #1;
      DMA_read = (c == ign);
      if (c == ign) begin
        DMA_address = a + 16'd333;
        DMA_count   = 7'd3;
      end
      @(negedge clk);
      exp_rd   = (c >= 1) && (c <= ni);
      exp_v    = (c >= 3) && (c <= ni + 2);
      exp_rdy  = (ni == 0) ? (c == 1) : (c == ni + 3);
      exp_busy = (ni == 0) ? (c == 1) : (c <= ni + 3);
      chk($sformatf("%s c%0d rd_en", name, c), {31'd0, mem_rd_en}, {31'd0, exp_rd});
      if (exp_rd) begin
        ea = a + 16'(c - 1);
        chk($sformatf("%s c%0d addr", name, c), {16'd0, mem_addr}, {16'd0, ea});
      end
      chk($sformatf("%s c%0d valid", name, c), {31'd0, data_valid}, {31'd0, exp_v});
      if (exp_v) begin
        ea = a + 16'(c - 3);
        chk($sformatf("%s c%0d index", name, c), {25'd0, data_index}, 32'(c - 3));
        chk($sformatf("%s c%0d data", name, c), {16'd0, data_out}, {16'd0, memval(ea)});
      end
      chk($sformatf("%s c%0d ready", name, c), {31'd0, DMA_ready}, {31'd0, exp_rdy});
      chk($sformatf("%s c%0d busy", name, c), {31'd0, busy}, {31'd0, exp_busy});
`ifdef DMA_ADDR_CHECK_EN
      chk($sformatf("%s c%0d error", name, c), {31'd0, DMA_error}, 0);
`endif
    end
    DMA_read = 1'b0;
  endtask

  initial begin
    rst = 1'b0; DMA_read = 1'b0; DMA_address = '0; DMA_count = '0; out_stall = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
`ifdef DMA_ADDR_CHECK_EN
    chk("reset error", {31'd0, DMA_error}, 0);
`endif
    @(posedge clk); #1; rst = 1'b1;

    // Long unstalled transfer: ready at T+123
    run_clean("n120", 16'd0, 7'd120, 0);

    // Backpressure: stall three cycles while word 5 is presented
    cnt = 0; rdy_cnt = 0; rdy_cyc = 0;
    @(posedge clk); #1;
    DMA_read = 1'b1; DMA_address = 16'd10164; DMA_count = 7'd85; out_stall = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 95; c++) begin
      @(posedge clk); #1;
      DMA_read  = 1'b0;
      out_stall = (c >= 8) && (c <= 10);
      @(negedge clk);
      if (out_stall) begin
        chk($sformatf("stall c%0d rd_en", c), {31'd0, mem_rd_en}, 0);
        chk($sformatf("stall c%0d valid", c), {31'd0, data_valid}, 1);
        chk($sformatf("stall c%0d index", c), {25'd0, data_index}, 5);
        chk($sformatf("stall c%0d data", c), {16'd0, data_out}, {16'd0, memval(16'd10169)});
      end else if (data_valid) begin
        tmp_a = 16'd10164 + 16'(cnt);
        chk($sformatf("stall c%0d index", c), {25'd0, data_index}, 32'(cnt));
        chk($sformatf("stall c%0d data", c), {16'd0, data_out}, {16'd0, memval(tmp_a)});
        cnt++;
      end
      if (DMA_ready) begin
        rdy_cnt++;
        rdy_cyc = c;
      end
    end
    out_stall = 1'b0;
    chk("stall words", 32'(cnt), 85);
    chk("stall ready count", 32'(rdy_cnt), 1);
    chk("stall ready cycle", 32'(rdy_cyc), 91);

    // Zero-length request
    run_clean("n0", 16'd500, 7'd0, 0);

    // Request pulsed mid-transfer is ignored
    run_clean("ignore", 16'd100, 7'd10, 5);

    // Abort by reset while word 40 is presented
    @(posedge clk); #1;
    DMA_read = 1'b1; DMA_address = 16'd0; DMA_count = 7'd120;
    @(negedge clk);
    for (int c = 1; c <= 43; c++) begin
      @(posedge clk); #1;
      DMA_read = 1'b0;
      if (c == 43) rst = 1'b0;
      @(negedge clk);
    end
    chk("abort pre valid", {31'd0, data_valid}, 1);
    chk("abort pre index", {25'd0, data_index}, 40);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    run_clean("after_rst", 16'd0, 7'd4, 0);

`ifdef DMA_ADDR_CHECK_EN
    // Out-of-range request: immediate completion with error
    @(posedge clk); #1;
    DMA_read = 1'b1; DMA_address = 16'd11000; DMA_count = 7'd20;
    @(negedge clk);
    @(posedge clk); #1; DMA_read = 1'b0;
    @(negedge clk);
    chk("err c1 ready", {31'd0, DMA_ready}, 1);
    chk("err c1 error", {31'd0, DMA_error}, 1);
    chk("err c1 busy", {31'd0, busy}, 1);
    chk("err c1 rd_en", {31'd0, mem_rd_en}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err c2 ready", {31'd0, DMA_ready}, 0);
    chk("err c2 error", {31'd0, DMA_error}, 0);
    chk("err c2 busy", {31'd0, busy}, 0);
    chk("err c2 rd_en", {31'd0, mem_rd_en}, 0);
    chk("err c2 valid", {31'd0, data_valid}, 0);
    // Exactly reaching MEM_DEPTH is legal; N=0 never errors
    run_clean("edge", 16'd10990, 7'd24, 0);
    run_clean("n0_high", 16'd65000, 7'd0, 0);
`else
    // No bounds check: plain read past MEM_DEPTH, then address wrap
    run_clean("range", 16'd11000, 7'd20, 0);
    run_clean("wrap", 16'd65530, 7'd10, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
